// File: rtl/alu_op_engine.sv
// ALU operation engine: pops {data_1, data_0, id, op} from FIFO_IN, executes
// ADD/SUB/AND or a shift-add MUL, and pushes {id, result} into FIFO_OUT.
module alu_op_engine #(
  parameter int DATA_SIZE      = 16,
  parameter int ID_SIZE        = 8,
  parameter int OPERATION_SIZE = 2,
  parameter int MUL_WIDTH      = 8,
  parameter int FIFO_IN_WIDTH  = 2*DATA_SIZE + ID_SIZE + OPERATION_SIZE,
  parameter int FIFO_OUT_WIDTH = ID_SIZE + DATA_SIZE + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
  input  logic                      fifo_in_empty,
  output logic                      fifo_in_r_en,
  input  logic                      fifo_out_full,
  output logic                      fifo_out_w_en,
  output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  output logic                      busy
);

  localparam int CNT_W = (MUL_WIDTH > 1) ? $clog2(MUL_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_WIDTH - 1);

  localparam logic [OPERATION_SIZE-1:0] OP_ADD = OPERATION_SIZE'(0);
  localparam logic [OPERATION_SIZE-1:0] OP_SUB = OPERATION_SIZE'(1);
  localparam logic [OPERATION_SIZE-1:0] OP_AND = OPERATION_SIZE'(2);
  localparam logic [OPERATION_SIZE-1:0] OP_MUL = OPERATION_SIZE'(3);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, PUSH} state_t;

  state_t                    state;
  logic [OPERATION_SIZE-1:0] op_q;
  logic [ID_SIZE-1:0]        id_q;
  logic [DATA_SIZE-1:0]      a_q;
  logic [DATA_SIZE-1:0]      b_q;
  logic [DATA_SIZE:0]        acc_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [DATA_SIZE:0] partial;
  logic [DATA_SIZE:0] mul_next;
  logic [DATA_SIZE:0] alu_result;
  logic               exec_done;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    partial = '0;
    if (b_q[cnt_q]) begin
      partial = {{(DATA_SIZE + 1 - MUL_WIDTH){1'b0}}, a_q[MUL_WIDTH-1:0]} << cnt_q;
    end
    mul_next = acc_q + partial;

    unique case (op_q)
      OP_ADD:  alu_result = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_result = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_result = {1'b0, a_q & b_q};
      default: alu_result = mul_next;
    endcase

    exec_done = (op_q != OP_MUL) || (cnt_q == CNT_LAST);
  end

  // NOTE: the pop strobe is qualified by rst_n so it drops the moment reset asserts,
  // even though the state register already sits in IDLE.
  assign fifo_in_r_en  = rst_n && (state == IDLE) && !fifo_in_empty;
  assign fifo_out_w_en = (state == PUSH) && !fifo_out_full;
  assign busy          = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      id_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      fifo_out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_in_empty) state <= LOAD;
        end
        LOAD: begin
          op_q  <= fifo_in_data[0 +: OPERATION_SIZE];
          id_q  <= fifo_in_data[OPERATION_SIZE +: ID_SIZE];
          a_q   <= fifo_in_data[OPERATION_SIZE + ID_SIZE +: DATA_SIZE];
          b_q   <= fifo_in_data[OPERATION_SIZE + ID_SIZE + DATA_SIZE +: DATA_SIZE];
          acc_q <= '0;
          cnt_q <= '0;
          state <= EXEC;
        end
        EXEC: begin
          // The final MUL iteration folds its partial product straight into the output.
          if (exec_done) begin
            fifo_out_data <= {id_q, alu_result};
            state         <= PUSH;
          end else begin
            acc_q <= mul_next;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PUSH: begin
          if (!fifo_out_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_engine.sv
// Self-checking bench for alu_op_engine: a FIFO_IN queue model, a transaction-level
// reference (result per entry, fixed latency, stall on full), and directed literal checks.
module tb_alu_op_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [41:0] fifo_in_data;
  logic        fifo_in_empty;
  logic        fifo_in_r_en;
  logic        fifo_out_full;
  logic        fifo_out_w_en;
  logic [24:0] fifo_out_data;
  logic        busy;

  alu_op_engine dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_in_data  (fifo_in_data),
    .fifo_in_empty (fifo_in_empty),
    .fifo_in_r_en  (fifo_in_r_en),
    .fifo_out_full (fifo_out_full),
    .fifo_out_w_en (fifo_out_w_en),
    .fifo_out_data (fifo_out_data),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [41:0] in_q[$];
  bit          pop_pending = 0;
  bit          full_req    = 0;

  // Reference model state: one entry in flight, its expected output and the
  // earliest cycle it may be pushed.
  bit          inflight = 0;
  logic [24:0] exp_entry = '0;
  int          due = 0;

  int          ren_log[$];
  int          wen_cyc[$];
  logic [24:0] wen_dat[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [41:0] mk(input int op, input int id, input int a, input int b);
    return {b[15:0], a[15:0], id[7:0], op[1:0]};
  endfunction

  function automatic logic [24:0] model(input logic [41:0] e);
    int op, id, a, b, r;
    op = int'(e[1:0]);
    id = int'(e[9:2]);
    a  = int'(e[25:10]);
    b  = int'(e[41:26]);
    case (op)
      0:       r = a + b;
      1:       r = a - b;
      2:       r = a & b;
      default: r = (a % 256) * (b % 256);
    endcase
    return {id[7:0], r[16:0]};
  endfunction

  function automatic int latency(input logic [41:0] e);
    return (e[1:0] == 2'b11) ? 10 : 3;
  endfunction

  // One clock cycle: drive FIFO inputs mid-cycle, then compare against the model.
  task automatic tick();
    bit exp_ren, exp_wen;
    @(negedge clk);
    cyc++;
    if (pop_pending && in_q.size() > 0) fifo_in_data = in_q.pop_front();
    else                                fifo_in_data = {$urandom, $urandom};
    pop_pending   = 0;
    fifo_in_empty = (in_q.size() == 0);
    fifo_out_full = full_req;
    #1;
    exp_ren = rst_n && !inflight && !fifo_in_empty;
    exp_wen = rst_n && inflight && (cyc >= due) && !fifo_out_full;
    check("r_en", fifo_in_r_en, exp_ren);
    check("w_en", fifo_out_w_en, exp_wen);
    check("busy", busy, inflight);
    if (inflight && cyc >= due) check("out_data", fifo_out_data, exp_entry);

    if (fifo_in_r_en) begin
      ren_log.push_back(cyc);
      pop_pending = 1;
    end
    if (fifo_out_w_en) begin
      wen_cyc.push_back(cyc);
      wen_dat.push_back(fifo_out_data);
    end
    if (exp_ren) begin
      inflight  = 1;
      exp_entry = model(in_q[0]);
      due       = cyc + latency(in_q[0]);
    end
    if (exp_wen) inflight = 0;
  endtask

  task automatic clear_logs();
    ren_log.delete();
    wen_cyc.delete();
    wen_dat.delete();
  endtask

  task automatic wait_ren(input int n, input int limit, input string name);
    int k;
    k = 0;
    while (ren_log.size() < n && k < limit) begin
      tick();
      k++;
    end
    check({name, "_ren_seen"}, ren_log.size() >= n, 1'b1);
  endtask

  function automatic int pick16();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 16'hFFFF;
      default: return int'($urandom_range(0, 16'hFFFF));
    endcase
  endfunction

  initial begin
    rst_n         = 1'b0;
    fifo_in_empty = 1'b0;
    fifo_out_full = 1'b0;
    fifo_in_data  = '0;
    #2;
    check("reset_r_en", fifo_in_r_en, 1'b0);
    check("reset_w_en", fifo_out_w_en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_data", fifo_out_data, 25'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // 1: ADD with carry out.
    clear_logs();
    in_q.push_back(mk(0, 8'h5A, 16'hFFFF, 16'h0001));
    repeat (10) tick();
    check("add_pushes", wen_cyc.size(), 1);
    if (ren_log.size() == 1 && wen_cyc.size() == 1) begin
      check("add_latency", wen_cyc[0] - ren_log[0], 3);
      check("add_data", wen_dat[0], {8'h5A, 17'h10000});
    end

    // 2: SUB with borrow, then AND, pushed in order.
    clear_logs();
    in_q.push_back(mk(1, 8'h01, 16'h0003, 16'h0005));
    in_q.push_back(mk(2, 8'h02, 16'hF0F0, 16'hFF00));
    repeat (14) tick();
    check("subaND_pushes", wen_cyc.size(), 2);
    if (wen_dat.size() == 2) begin
      check("sub_data", wen_dat[0], {8'h01, 17'h1FFFE});
      check("and_data", wen_dat[1], {8'h02, 17'h0F000});
    end

    // 3: MUL uses only the low bytes.
    clear_logs();
    in_q.push_back(mk(3, 8'h33, 16'h12FF, 16'hABFF));
    repeat (16) tick();
    check("mul_pushes", wen_cyc.size(), 1);
    if (ren_log.size() == 1 && wen_cyc.size() == 1) begin
      check("mul_latency", wen_cyc[0] - ren_log[0], 10);
      check("mul_data", wen_dat[0], {8'h33, 17'h0FE01});
    end

    // 4: backpressure for 5 PUSH cycles, then the next queued entry.
    clear_logs();
    full_req = 1;
    in_q.push_back(mk(0, 8'h44, 16'h0001, 16'h0002));
    in_q.push_back(mk(2, 8'h45, 16'h1234, 16'h00FF));
    wait_ren(1, 10, "bp");
    repeat (7) tick();
    check("bp_no_push", wen_cyc.size(), 0);
    check("bp_hold", fifo_out_data, {8'h44, 17'h00003});
    full_req = 0;
    repeat (10) tick();
    if (ren_log.size() >= 2 && wen_cyc.size() >= 1) begin
      check("bp_wen_cycle", wen_cyc[0] - ren_log[0], 8);
      check("bp_next_pop", ren_log[1] - wen_cyc[0], 1);
      check("bp_data", wen_dat[0], {8'h44, 17'h00003});
    end else begin
      check("bp_progress", ren_log.size() >= 2 && wen_cyc.size() >= 1, 1'b1);
    end

    // 5: idle with empty FIFO, then reset in the middle of a MUL.
    clear_logs();
    repeat (20) tick();
    check("idle_no_pop", ren_log.size(), 0);
    in_q.push_back(mk(3, 8'h77, 16'h00AB, 16'h00CD));
    wait_ren(1, 10, "abort");
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("abort_r_en", fifo_in_r_en, 1'b0);
    check("abort_w_en", fifo_out_w_en, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_data", fifo_out_data, 25'h0);
    inflight    = 0;
    pop_pending = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("abort_no_push", wen_cyc.size(), 0);
    check("abort_no_pop", ren_log.size(), 1);

    // Randomized traffic with random backpressure.
    clear_logs();
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0 && in_q.size() < 4)
        in_q.push_back(mk($urandom_range(0, 3), $urandom_range(0, 255), pick16(), pick16()));
      full_req = ($urandom_range(0, 3) == 0);
      tick();
    end
    full_req = 0;
    for (int k = 0; k < 80 && (in_q.size() > 0 || inflight || pop_pending); k++) tick();
    check("drain_done", in_q.size() + int'(inflight) + int'(pop_pending), 0);
    check("rand_balance", ren_log.size(), wen_cyc.size());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
